id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Hazard and forwarding controller for the ID stage of the 5-stage RV32I pipeline.
- Shadows the destination register, write-enable and load flag of the instructions in EX and MEM.
- Drives the 2-bit forward selects consumed by the ID-stage operand mux.
- Generates load-use stall, data-memory wait freeze and branch flush controls for the pipeline registers.

Parameters:
- XLEN_CNT, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  5  source register 1 of the ID instruction.
- id_rs2  in  5  source register 2 of the ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  5  destination of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- branch_taken_ex  in  1  branch/jump in EX is redirecting the PC.
- mem_ready  in  1  data memory has completed the access of the MEM-stage instruction.
- forward_data1  out  2  rs1 select: 00 regfile, 01 EX, 10 MEM.
- forward_data2  out  2  rs2 select, same encoding.
- stall_if  out  1  hold PC and IF/ID register.
- stall_id  out  1  hold ID stage and insert a bubble into EX.
- freeze  out  1  hold every pipeline register (memory wait).
- flush_id  out  1  squash IF/ID contents.
- stall_cycles  out  XLEN_CNT  saturating count of cycles with freeze or stall_id.

Behaviour:
- Shadow registers: ex_valid/ex_rd/ex_wr/ex_load and mem_valid/mem_rd/mem_wr/mem_load.
- Reset: all shadow registers cleared, state RUN, stall_cycles = 0.
- All outputs 0 during and immediately after reset, as they are derived from cleared state.
- "EX hit rsN": ex_valid & ex_wr & ex_rd != 0 & ex_rd == id_rsN & id_use_rsN.
- "MEM hit rsN": same test using the mem_* shadow registers.
- Register x0 is never forwarded and never causes a stall.
- forward_dataN is combinational (zero latency):
  - 01 on an EX hit without ex_load;
  - else 10 on a MEM hit;
  - else 00.
  - EX takes priority over MEM for the same register.
  - Value 11 is never driven.
- Load-use: an EX hit with ex_load raises stall_id = stall_if = 1 for exactly one cycle.
  - forward_dataN = 00 during that cycle.
  - The following cycle the load is in MEM, so the select is 10.
- State machine RUN / MEM_WAIT:
  - RUN -> MEM_WAIT: when mem_valid & mem_load & !mem_ready.
  - MEM_WAIT -> RUN: on the first cycle mem_ready = 1.
  - freeze = 1 in any cycle where mem_valid & mem_load & !mem_ready, including the entry cycle (combinational).
  - stall_if = 1 whenever freeze = 1.
- Shadow update when freeze = 0:
  - mem_* <= ex_*.
  - ex_* <= bubble (ex_valid = 0) if stall_id or flush_id.
  - Otherwise ex_* <= id_* with ex_valid = id_valid.
- Shadow update when freeze = 1: all shadow registers hold.
- flush_id = branch_taken_ex & !freeze.
  - The branch is held by the frozen pipeline and flushes after the freeze ends.
- Output priority: freeze > flush_id > load-use stall.
  - While flush_id = 1, stall_id = 0; the ID instruction is dead.
- stall_cycles increments when freeze | stall_id and saturates at all-ones.
- Reset asserted mid-freeze or mid-stall returns to RUN with cleared shadows on the same edge (asynchronous).
- id_valid = 0 suppresses all hits and stalls for the ID instruction.

Decomposition:
- Shared package holds:
  - forward select constants: FWD_NONE=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10;
  - state encoding for RUN and MEM_WAIT;
  - REG_ZERO=5'd0.
- One natural sub-module, hazard_match: combinational compare of one source operand against both shadow stages. It returns ex_hit, ex_load_hit and mem_hit, and is instantiated twice (rs1, rs2).

Test Plan:
- ADD x5 into EX; ID reads rs1=x5 -> forward_data1=01, forward_data2=00, no stall.
- LW x7 into EX; ID reads rs2=x7, mem_ready=1 -> cycle1: stall_id=stall_if=1, fwd2=00; cycle2: fwd2=10, no stall; stall_cycles=1.
- ADD writing x0 in EX; ID reads rs1=x0 -> forward_data1=00, no stall.
- EX writes x3, MEM writes x3; ID reads rs1=x3 -> forward_data1=01 (EX priority).
- LW in MEM with mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, shadows unchanged, stall_cycles=3, RUN on the 4th cycle.
- branch_taken_ex=1 while ID load-use matches -> flush_id=1, stall_id=0, ex_valid=0 next cycle.
- Repeat with freeze active -> flush_id=0 until mem_ready rises.
- rst_n low during MEM_WAIT -> all outputs 0 immediately; RUN after release.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding controller.
package id_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Shadow of one downstream pipeline stage.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, rd: REG_ZERO, wr: 1'b0, load: 1'b0};

  // True when the stage will write a non-zero register equal to r.
  function automatic logic writes_reg(stage_t s, logic [REG_W-1:0] r);
    return s.valid & s.wr & (s.rd != REG_ZERO) & (s.rd == r);
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_hazard_match.sv
// Compares one ID source operand against the EX and MEM shadow stages.
module hazard_match
  import id_hazard_ctrl_pkg::*;
(
  input  logic             id_valid,
  input  logic             use_rs,
  input  logic [REG_W-1:0] rs,
  input  stage_t           ex,
  input  stage_t           mem,
  output logic             ex_hit,
  output logic             ex_load_hit,
  output logic             mem_hit
);

  logic reads_c;

  assign reads_c     = id_valid & use_rs;
  assign ex_hit      = reads_c & writes_reg(ex, rs);
  assign ex_load_hit = ex_hit & ex.load;
  assign mem_hit     = reads_c & writes_reg(mem, rs);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: operand forwarding selects, load-use stall,
// data-memory wait freeze, branch flush and a saturating stall counter.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN_CNT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_reg_write,
  input  logic                id_is_load,
  input  logic                branch_taken_ex,
  input  logic                mem_ready,
  output logic [FWD_W-1:0]    forward_data1,
  output logic [FWD_W-1:0]    forward_data2,
  output logic                stall_if,
  output logic                stall_id,
  output logic                freeze,
  output logic                flush_id,
  output logic [XLEN_CNT-1:0] stall_cycles
);

  stage_t              ex_q, ex_d;
  stage_t              mem_q, mem_d;
  state_e              state_q, state_d;
  logic [XLEN_CNT-1:0] stall_cycles_q, stall_cycles_d;

  logic ex_hit1, ex_load_hit1, mem_hit1;
  logic ex_hit2, ex_load_hit2, mem_hit2;
  logic freeze_c, flush_c, stall_id_c, stall_if_c;
  logic [FWD_W-1:0] fwd1_c, fwd2_c;

  hazard_match u_match_rs1 (
    .id_valid    (id_valid),
    .use_rs      (id_use_rs1),
    .rs          (id_rs1),
    .ex          (ex_q),
    .mem         (mem_q),
    .ex_hit      (ex_hit1),
    .ex_load_hit (ex_load_hit1),
    .mem_hit     (mem_hit1)
  );

  hazard_match u_match_rs2 (
    .id_valid    (id_valid),
    .use_rs      (id_use_rs2),
    .rs          (id_rs2),
    .ex          (ex_q),
    .mem         (mem_q),
    .ex_hit      (ex_hit2),
    .ex_load_hit (ex_load_hit2),
    .mem_hit     (mem_hit2)
  );

  // An EX producer always shadows MEM; a pending load forces the regfile path.
  function automatic logic [FWD_W-1:0] fwd_sel(logic ex_hit, logic ex_load_hit, logic mem_hit);
    if (ex_hit)       return ex_load_hit ? FWD_NONE : FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else              return FWD_NONE;
  endfunction

  always_comb begin
    fwd1_c         = fwd_sel(ex_hit1, ex_load_hit1, mem_hit1);
    fwd2_c         = fwd_sel(ex_hit2, ex_load_hit2, mem_hit2);
    freeze_c       = mem_q.valid & mem_q.load & ~mem_ready;
    flush_c        = branch_taken_ex & ~freeze_c;
    stall_id_c     = (ex_load_hit1 | ex_load_hit2) & ~freeze_c & ~flush_c;
    stall_if_c     = freeze_c | stall_id_c;
    state_d        = state_q;
    ex_d           = ex_q;
    mem_d          = mem_q;
    stall_cycles_d = stall_cycles_q;

    unique case (state_q)
      ST_RUN:      if (freeze_c)  state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_ready) state_d = ST_RUN;
      default:                    state_d = ST_RUN;
    endcase

    // A frozen pipeline holds every shadow; otherwise advance one stage.
    if (!freeze_c) begin
      mem_d = ex_q;
      if (stall_id_c || flush_c) begin
        ex_d = STAGE_BUBBLE;
      end else begin
        ex_d.valid = id_valid;
        ex_d.rd    = id_rd;
        ex_d.wr    = id_reg_write;
        ex_d.load  = id_is_load;
      end
    end

    if ((freeze_c || stall_id_c) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + XLEN_CNT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      ex_q           <= STAGE_BUBBLE;
      mem_q          <= STAGE_BUBBLE;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign forward_data1 = fwd1_c;
  assign forward_data2 = fwd2_c;
  assign freeze        = freeze_c;
  assign flush_id      = flush_c;
  assign stall_id      = stall_id_c;
  assign stall_if      = stall_if_c;
  assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed scenarios followed by random
// traffic, checked against an instruction-level model of the pipeline.
module tb_id_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;
  localparam int          N_RAND  = 3000;

  bit               clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic             branch_taken_ex, mem_ready;
  logic [1:0]       forward_data1, forward_data2;
  logic             stall_if, stall_id, freeze, flush_id;
  logic [CNT_W-1:0] stall_cycles;

  id_hazard_ctrl #(.XLEN_CNT(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_is_load      (id_is_load),
    .branch_taken_ex (branch_taken_ex),
    .mem_ready       (mem_ready),
    .forward_data1   (forward_data1),
    .forward_data2   (forward_data2),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .freeze          (freeze),
    .flush_id        (flush_id),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit load;
  } instr_t;

  typedef struct {
    int fwd1;
    int fwd2;
    bit stall_if;
    bit stall_id;
    bit freeze;
    bit flush_id;
    int cnt;
  } exp_t;

  exp_t   exp_q[$];
  instr_t m_ex, m_mem;
  int     m_cnt;
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 1'b0; b.rd = 0; b.wr = 1'b0; b.load = 1'b0;
    return b;
  endfunction

  function automatic bit produces(instr_t p, int r, bit reads);
    return reads && p.valid && p.wr && (r != 0) && (p.rd == r);
  endfunction

  // Youngest producer wins; a load still in EX has no value yet.
  function automatic int expect_fwd(int r, bit reads);
    if (produces(m_ex, r, reads))  return m_ex.load ? 0 : 1;
    if (produces(m_mem, r, reads)) return 2;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of ID-side stimulus, predict the outputs, advance the model.
  task automatic step(input bit rst, input bit v, input int rs1, input int rs2,
                      input bit u1, input bit u2, input int rd, input bit wr,
                      input bit ld, input bit br, input bit mr);
    exp_t   e;
    instr_t nx;
    bit     r1, r2, lu;
    @(posedge clk);
    #1;
    if (!rst) br = 1'b0;
    rst_n           = rst;
    id_valid        = v;
    id_rs1          = 5'(rs1);
    id_rs2          = 5'(rs2);
    id_use_rs1      = u1;
    id_use_rs2      = u2;
    id_rd           = 5'(rd);
    id_reg_write    = wr;
    id_is_load      = ld;
    branch_taken_ex = br;
    mem_ready       = mr;

    if (!rst) begin
      m_ex  = bubble();
      m_mem = bubble();
      m_cnt = 0;
    end
    r1 = v && u1;
    r2 = v && u2;
    e.freeze   = m_mem.valid && m_mem.load && !mr;
    e.flush_id = br && !e.freeze;
    lu = (produces(m_ex, rs1, r1) || produces(m_ex, rs2, r2)) && m_ex.load;
    e.stall_id = lu && !e.freeze && !e.flush_id;
    e.stall_if = e.freeze || e.stall_id;
    e.fwd1     = expect_fwd(rs1, r1);
    e.fwd2     = expect_fwd(rs2, r2);
    e.cnt      = m_cnt;
    exp_q.push_back(e);

    if (rst) begin
      if (!e.freeze) begin
        m_mem = m_ex;
        if (e.stall_id || e.flush_id) begin
          m_ex = bubble();
        end else begin
          nx.valid = v; nx.rd = rd; nx.wr = wr; nx.load = ld;
          m_ex = nx;
        end
      end
      if ((e.freeze || e.stall_id) && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic nop(input bit mr);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, mr);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("forward_data1", int'(forward_data1), e.fwd1);
      check("forward_data2", int'(forward_data2), e.fwd2);
      check("stall_if",      int'(stall_if),      int'(e.stall_if));
      check("stall_id",      int'(stall_id),      int'(e.stall_id));
      check("freeze",        int'(freeze),        int'(e.freeze));
      check("flush_id",      int'(flush_id),      int'(e.flush_id));
      check("stall_cycles",  int'(stall_cycles),  e.cnt);
    end
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0; id_is_load = 1'b0;
    branch_taken_ex = 1'b0; mem_ready = 1'b1;
    m_ex = bubble(); m_mem = bubble(); m_cnt = 0;

    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1'b0, 1, 5, 5, 1, 1, 5, 1, 0, 0, 1);
    // ADD x5 then a reader of x5 on rs1
    step(1'b1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
    step(1'b1, 1, 5, 0, 1, 0, 6, 1, 0, 0, 1);
    // LW x7 then rs2=x7: one stall, then MEM forward on the held instruction
    step(1'b1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 1);
    step(1'b1, 1, 0, 7, 0, 1, 8, 1, 0, 0, 1);
    step(1'b1, 1, 0, 7, 0, 1, 8, 1, 0, 0, 1);
    // x0 producer is never forwarded
    step(1'b1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(1'b1, 1, 0, 0, 1, 0, 8, 1, 0, 0, 1);
    // x3 in both EX and MEM: EX wins
    step(1'b1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    step(1'b1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    step(1'b1, 1, 3, 0, 1, 0, 8, 1, 0, 0, 1);
    // load in MEM waits three cycles
    step(1'b1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 1);
    nop(1'b1);
    repeat (3) step(1'b1, 1, 1, 2, 1, 1, 4, 1, 0, 0, 0);
    step(1'b1, 1, 1, 2, 1, 1, 4, 1, 0, 0, 1);
    // branch overrides a load-use stall
    step(1'b1, 1, 0, 0, 0, 0, 10, 1, 1, 0, 1);
    step(1'b1, 1, 10, 0, 1, 0, 4, 1, 0, 1, 1);
    step(1'b1, 1, 10, 0, 1, 0, 4, 1, 0, 0, 1);
    // branch held off by a freeze
    step(1'b1, 1, 0, 0, 0, 0, 11, 1, 1, 0, 1);
    nop(1'b1);
    repeat (2) step(1'b1, 1, 0, 0, 0, 0, 4, 1, 0, 1, 0);
    step(1'b1, 1, 0, 0, 0, 0, 4, 1, 0, 1, 1);
    // reset in the middle of a memory wait
    step(1'b1, 1, 0, 0, 0, 0, 12, 1, 1, 0, 1);
    nop(1'b1);
    step(1'b1, 1, 12, 12, 1, 1, 4, 1, 0, 0, 0);
    step(1'b0, 1, 12, 12, 1, 1, 4, 1, 0, 0, 0);
    nop(1'b0);

    for (int i = 0; i < N_RAND; i++) begin
      step($urandom_range(0, 299) != 0,
           $urandom_range(0, 9) != 0,
           int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 4)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
